dpram_stream_out: RTL and testbench
===================================

DPRAM_STREAM_OUT -- requirements
Module: dpram_stream_out

Interface
REQ-001 Parameter P_DPRAM_ADR_WIDTH, default 10: DPRAM word-address width.
REQ-002 Parameter P_RD_LAT, default 2: DPRAM read latency in clk cycles, from address to data; legal range 1-3.
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 dpram_run  input  1  one-cycle pulse from the waveform-buffer reader: DPRAM filled, start draining.
REQ-006 dpram_len  input  16  number of valid 32-bit words in the DPRAM; sampled on the dpram_run cycle.
REQ-007 dpram_busy  output  1  high from acceptance of dpram_run until the drain completes.
REQ-008 dpram_rd_addr  output  P_DPRAM_ADR_WIDTH  DPRAM read address.
REQ-009 dpram_rd_data  input  32  DPRAM read data, valid P_RD_LAT cycles after the address.
REQ-010 out_data  output  8  byte stream to the host link.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  sink accepts a byte when out_valid && out_ready (a "beat").
REQ-013 words_sent  output  32  running count of DPRAM words streamed; wraps at 2^32.

Function
REQ-014 States: S_IDLE, S_LEN_HI, S_LEN_LO, S_FETCH, S_WAIT, S_SHIFT, S_DONE.
REQ-015 In S_IDLE, a dpram_run pulse shall latch len = min(dpram_len, 2^P_DPRAM_ADR_WIDTH), set dpram_busy on the next cycle, and move the FSM to S_LEN_HI.
REQ-016 A dpram_run pulse while dpram_busy is high shall be ignored, with no change to state, len, or counters.
REQ-017 S_LEN_HI shall present len[15:8] with out_valid=1; on a beat the FSM moves to S_LEN_LO, which presents len[7:0].
REQ-018 After the S_LEN_LO beat, the FSM moves to S_FETCH if len>0, or to S_DONE if len=0.
REQ-019 S_FETCH shall drive dpram_rd_addr = word index (starting at 0) for exactly one cycle, then move to S_WAIT.
REQ-020 S_WAIT shall hold P_RD_LAT cycles, then capture dpram_rd_data into a 32-bit shift register and move to S_SHIFT.
REQ-021 S_SHIFT shall emit 4 bytes, MSB first ([31:24], [23:16], [15:8], [7:0]), one per beat.
REQ-022 While out_ready=0, out_data and out_valid shall hold stable; no byte is dropped or duplicated.
REQ-023 On the 4th beat of a word, words_sent shall increment and the word index shall increment.
REQ-024 After that 4th beat, the FSM moves to S_FETCH if the index is below len, otherwise to S_DONE.
REQ-025 S_DONE shall deassert dpram_busy and out_valid on the next cycle and return to S_IDLE; a dpram_run in that S_IDLE cycle shall be accepted.
REQ-026 out_valid shall be 0 in S_IDLE, S_FETCH, S_WAIT and S_DONE.
REQ-027 Total bytes per transfer shall be 2 + 4*len.
REQ-028 dpram_rd_addr shall hold its last value outside S_FETCH.
REQ-029 The word index shall be P_DPRAM_ADR_WIDTH+1 bits wide so that len = 2^P_DPRAM_ADR_WIDTH terminates correctly.

Reset
REQ-030 rst shall force S_IDLE and clear dpram_busy, out_valid, out_data, dpram_rd_addr, words_sent, len, the index and the shift register, with outputs 0 from the following cycle.
REQ-031 rst mid-transfer shall abort the transfer with no further beats; the partially sent data is discarded.

Verification
REQ-032 len=3, words 0xA1B2C3D4, 0x11223344, 0xDEADBEEF, out_ready=1 -> bytes 00 03 A1 B2 C3 D4 11 22 33 44 DE AD BE EF; busy drops after the last beat; words_sent=3.
REQ-033 len=0 -> exactly 2 bytes (00 00); busy high for the transfer and low afterwards; words_sent unchanged.
REQ-034 len=2 with out_ready randomly toggled at 50% -> identical byte sequence, out_data stable during stalls.
REQ-035 len=0xFFFF with P_DPRAM_ADR_WIDTH=10 -> header 04 00, 1024 words read from addresses 0..1023, no address wrap.
REQ-036 A second dpram_run mid-transfer -> ignored; rst asserted after the 5th byte -> busy=0 and out_valid=0 next cycle; a fresh run afterwards streams correctly.
REQ-037 Repeat REQ-032 for P_RD_LAT=1 and P_RD_LAT=3 -> the same byte sequence.

Source files
------------

// File: rtl/dpram_stream_out.sv
// Drains a filled DPRAM as a byte stream: 16-bit length header (MSB first), then each
// 32-bit word MSB first, with valid/ready flow control toward the host link.
module dpram_stream_out #(
  parameter int unsigned P_DPRAM_ADR_WIDTH = 10,
  parameter int unsigned P_RD_LAT          = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dpram_run,
  input  logic [15:0]                  dpram_len,
  output logic                         dpram_busy,
  output logic [P_DPRAM_ADR_WIDTH-1:0] dpram_rd_addr,
  input  logic [31:0]                  dpram_rd_data,
  output logic [7:0]                   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  words_sent
);

  localparam int unsigned LP_IDX_W   = P_DPRAM_ADR_WIDTH + 1;
  localparam logic [16:0] LP_MAX_LEN = 17'(1) << P_DPRAM_ADR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_FETCH,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                         r_state, w_state_nxt;
  logic [15:0]                    r_len, w_len_nxt;
  logic [LP_IDX_W-1:0]            r_idx, w_idx_nxt, w_idx_inc;
  logic [P_DPRAM_ADR_WIDTH-1:0]   r_addr, w_addr_nxt;
  logic [31:0]                    r_shift, w_shift_nxt;
  logic [1:0]                     r_byte_cnt, w_byte_cnt_nxt;
  logic [1:0]                     r_wait, w_wait_nxt;
  logic [31:0]                    r_words_sent, w_words_nxt;
  logic                           w_beat;

  assign w_idx_inc = r_idx + LP_IDX_W'(1);
  assign w_beat    = out_valid && out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_len_nxt      = r_len;
    w_idx_nxt      = r_idx;
    w_addr_nxt     = r_addr;
    w_shift_nxt    = r_shift;
    w_byte_cnt_nxt = r_byte_cnt;
    w_wait_nxt     = r_wait;
    w_words_nxt    = r_words_sent;
    unique case (r_state)
      S_IDLE: begin
        if (dpram_run) begin
          w_len_nxt   = ({1'b0, dpram_len} > LP_MAX_LEN) ? LP_MAX_LEN[15:0] : dpram_len;
          w_idx_nxt   = '0;
          w_state_nxt = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (w_beat) w_state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (w_beat) w_state_nxt = (r_len != 16'd0) ? S_FETCH : S_DONE;
      end
      S_FETCH: begin
        w_addr_nxt  = r_idx[P_DPRAM_ADR_WIDTH-1:0];
        w_wait_nxt  = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Address is held after S_FETCH, so the data stays valid while we count.
        if (r_wait == 2'(P_RD_LAT - 1)) begin
          w_shift_nxt    = dpram_rd_data;
          w_byte_cnt_nxt = '0;
          w_state_nxt    = S_SHIFT;
        end else begin
          w_wait_nxt = r_wait + 2'd1;
        end
      end
      S_SHIFT: begin
        if (w_beat) begin
          w_shift_nxt    = {r_shift[23:0], 8'h00};
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            w_words_nxt = r_words_sent + 32'd1;
            w_idx_nxt   = w_idx_inc;
            w_state_nxt = (16'(w_idx_inc) < r_len) ? S_FETCH : S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_idx        <= '0;
      r_addr       <= '0;
      r_shift      <= '0;
      r_byte_cnt   <= '0;
      r_wait       <= '0;
      r_words_sent <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_len        <= w_len_nxt;
      r_idx        <= w_idx_nxt;
      r_addr       <= w_addr_nxt;
      r_shift      <= w_shift_nxt;
      r_byte_cnt   <= w_byte_cnt_nxt;
      r_wait       <= w_wait_nxt;
      r_words_sent <= w_words_nxt;
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    unique case (r_state)
      S_LEN_HI: begin
        out_valid = 1'b1;
        out_data  = r_len[15:8];
      end
      S_LEN_LO: begin
        out_valid = 1'b1;
        out_data  = r_len[7:0];
      end
      S_SHIFT: begin
        out_valid = 1'b1;
        out_data  = r_shift[31:24];
      end
      default: begin
        out_valid = 1'b0;
        out_data  = 8'h00;
      end
    endcase
  end

  assign dpram_busy    = (r_state != S_IDLE);
  assign dpram_rd_addr = (r_state == S_FETCH) ? r_idx[P_DPRAM_ADR_WIDTH-1:0] : r_addr;
  assign words_sent    = r_words_sent;

endmodule

// File: tb/tb_dpram_stream_out.sv
// Runs three instances (read latency 1, 2, 3) off one stimulus and checks each byte stream
// against a queue-based model of header + MSB-first words.
module tb_dpram_stream_out;

  localparam int unsigned AW    = 10;
  localparam int unsigned NL    = 3;
  localparam int unsigned DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic        dpram_run;
  logic [15:0] dpram_len;
  logic        out_ready;

  logic          w_busy      [NL];
  logic [AW-1:0] w_addr      [NL];
  logic [31:0]   w_rd_data   [NL];
  logic [7:0]    w_out_data  [NL];
  logic          w_out_valid [NL];
  logic [31:0]   w_words     [NL];

  logic [31:0] mem  [DEPTH];
  logic [31:0] pipe [NL][3];
  logic [7:0]  obs_q [NL][$];
  logic        prev_stall [NL];
  logic [7:0]  prev_data  [NL];
  int          ws_exp     [NL];
  int          n_cmp = 0;
  int          n_err = 0;
  int          rdy_mode = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    dpram_stream_out #(
      .P_DPRAM_ADR_WIDTH(AW),
      .P_RD_LAT         (g + 1)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .dpram_run    (dpram_run),
      .dpram_len    (dpram_len),
      .dpram_busy   (w_busy[g]),
      .dpram_rd_addr(w_addr[g]),
      .dpram_rd_data(w_rd_data[g]),
      .out_data     (w_out_data[g]),
      .out_valid    (w_out_valid[g]),
      .out_ready    (out_ready),
      .words_sent   (w_words[g])
    );
    assign w_rd_data[g] = pipe[g][g];
  end

  // DPRAM model: lane k returns mem[addr] k+1 cycles after the address.
  always @(posedge clk) begin
    for (int k = 0; k < NL; k++) begin
      pipe[k][0] <= mem[w_addr[k]];
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Beat collection and stall-stability checks, sampled mid-cycle.
  initial begin
    for (int k = 0; k < NL; k++) prev_stall[k] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NL; k++) begin
        if (rst) begin
          prev_stall[k] = 1'b0;
        end else begin
          if (prev_stall[k]) begin
            check_eq($sformatf("stall_valid_l%0d", k), 32'(w_out_valid[k]), 32'd1);
            check_eq($sformatf("stall_data_l%0d", k), 32'(w_out_data[k]), 32'(prev_data[k]));
          end
          if (w_out_valid[k] && out_ready) obs_q[k].push_back(w_out_data[k]);
          prev_stall[k] = w_out_valid[k] && !out_ready;
          prev_data[k]  = w_out_data[k];
        end
      end
    end
  end

  function automatic bit any_busy();
    for (int k = 0; k < NL; k++) if (w_busy[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle(input string tag);
    int cyc = 0;
    while (any_busy() && cyc < 40000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq({tag, "_idle"}, 32'(any_busy()), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    for (int k = 0; k < NL; k++) begin
      check_eq($sformatf("%s_busy_l%0d", tag, k), 32'(w_busy[k]), 32'd0);
      check_eq($sformatf("%s_valid_l%0d", tag, k), 32'(w_out_valid[k]), 32'd0);
      check_eq($sformatf("%s_data_l%0d", tag, k), 32'(w_out_data[k]), 32'd0);
      check_eq($sformatf("%s_addr_l%0d", tag, k), 32'(w_addr[k]), 32'd0);
      check_eq($sformatf("%s_words_l%0d", tag, k), w_words[k], 32'd0);
    end
  endtask

  task automatic start_run(input logic [15:0] len_in);
    dpram_run = 1'b1;
    dpram_len = len_in;
    @(posedge clk);
    #1;
    dpram_run = 1'b0;
    dpram_len = 16'($urandom);
  endtask

  task automatic run_xfer(input string tag, input logic [15:0] len_in, input bit inject_run);
    int       base [NL];
    int       n_words;
    int       err0;
    logic [7:0] exp_q[$];
    logic [7:0] got;
    n_words = (int'(len_in) > int'(DEPTH)) ? int'(DEPTH) : int'(len_in);
    exp_q = {};
    exp_q.push_back(8'(n_words >> 8));
    exp_q.push_back(8'(n_words));
    for (int i = 0; i < n_words; i++)
      for (int b = 3; b >= 0; b--) exp_q.push_back(8'(mem[i] >> (8 * b)));
    for (int k = 0; k < NL; k++) base[k] = obs_q[k].size();
    start_run(len_in);
    for (int k = 0; k < NL; k++)
      check_eq($sformatf("%s_busy_l%0d", tag, k), 32'(w_busy[k]), 32'd1);
    if (inject_run) begin
      repeat (6) @(posedge clk);
      #1;
      start_run(16'h0005);
    end
    wait_idle(tag);
    for (int k = 0; k < NL; k++) begin
      check_eq($sformatf("%s_count_l%0d", tag, k), 32'(obs_q[k].size() - base[k]),
               32'(exp_q.size()));
      err0 = n_err;
      for (int i = 0; i < exp_q.size(); i++) begin
        got = (base[k] + i < obs_q[k].size()) ? obs_q[k][base[k] + i] : 8'hxx;
        check_eq($sformatf("%s_byte%0d_l%0d", tag, i, k), 32'(got), 32'(exp_q[i]));
        if (n_err != err0) break;
      end
      ws_exp[k] += n_words;
      check_eq($sformatf("%s_words_l%0d", tag, k), w_words[k], 32'(ws_exp[k]));
    end
  endtask

  initial begin
    int base1;
    int cyc;
    int n_at [NL];
    rst       = 1'b1;
    dpram_run = 1'b0;
    dpram_len = 16'd0;
    for (int k = 0; k < NL; k++) ws_exp[k] = 0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    mem[0] = 32'hA1B2_C3D4;
    mem[1] = 32'h1122_3344;
    mem[2] = 32'hDEAD_BEEF;
    run_xfer("len3", 16'd3, 1'b0);
    run_xfer("len0", 16'd0, 1'b0);

    rdy_mode = 1;
    mem[0] = $urandom;
    mem[1] = $urandom;
    run_xfer("len2_stall", 16'd2, 1'b0);
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = $urandom;
    run_xfer("len_ffff", 16'hFFFF, 1'b0);
    repeat (4) run_xfer("rand", 16'($urandom_range(0, 40)), 1'b0);
    rdy_mode = 0;
    run_xfer("len1024", 16'd1024, 1'b0);
    run_xfer("len1025", 16'd1025, 1'b0);

    rdy_mode = 1;
    run_xfer("midrun", 16'd6, 1'b1);

    // Abort a transfer after its 5th byte, then confirm a clean restart.
    base1 = obs_q[1].size();
    start_run(16'd8);
    cyc = 0;
    while (obs_q[1].size() - base1 < 5 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("abort_reached5", 32'(obs_q[1].size() - base1 >= 5), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_outputs_zero("abort");
    rst = 1'b0;
    for (int k = 0; k < NL; k++) begin
      ws_exp[k] = 0;
      n_at[k]   = obs_q[k].size();
    end
    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < NL; k++)
      check_eq($sformatf("abort_nobeats_l%0d", k), 32'(obs_q[k].size()), 32'(n_at[k]));
    mem[0] = 32'hA1B2_C3D4;
    mem[1] = 32'h1122_3344;
    mem[2] = 32'hDEAD_BEEF;
    rdy_mode = 0;
    run_xfer("after_rst", 16'd3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
